// File: rtl/sm_display_scan_if.sv
// ----------------------------------------------------------------------------
// sm_display_scan_if
//
// Bundle between a value source and the 3-digit seven-segment scanner.
//
// Signals:
//   value      [11:0]  hex value to show; [3:0] is digit 0 (rightmost)
//   dp         [2:0]   decimal point request per digit (bit i -> digit i)
//   lzb_en             leading-zero blanking enable
//   seg        [6:0]   segment drive {g,f,e,d,c,b,a}
//   seg_dp             decimal point segment drive
//   dig_sel    [2:0]   digit enables, at most one active at a time
//   frame_tick         one-cycle pulse at the start of every frame
//
// Modports:
//   master : the side that supplies value/dp/lzb_en and observes the drive
//   slave  : the scanner itself
// ----------------------------------------------------------------------------
interface sm_display_scan_if;
    logic [11:0] value;
    logic [2:0]  dp;
    logic        lzb_en;
    logic [6:0]  seg;
    logic        seg_dp;
    logic [2:0]  dig_sel;
    logic        frame_tick;

    modport master (
        output value,
        output dp,
        output lzb_en,
        input  seg,
        input  seg_dp,
        input  dig_sel,
        input  frame_tick
    );

    modport slave (
        input  value,
        input  dp,
        input  lzb_en,
        output seg,
        output seg_dp,
        output dig_sel,
        output frame_tick
    );
endinterface

// File: rtl/sm_display_scan.sv
// ----------------------------------------------------------------------------
// sm_display_scan
//
// Time-multiplexed driver for a 3-digit common-segment seven-segment display.
// Each digit owns a slot of DIV clock cycles; the first BLANK cycles of every
// slot keep all digits and segments dark so the previous digit's pattern can
// not ghost onto the next one. The displayed value, decimal points and the
// blanking enable are captured once per frame (slot 0, cnt 0) so a frame is
// always drawn from one consistent snapshot.
//
// Ports:
//   clkIn   system clock
//   rst_n   asynchronous active-low reset; drives all outputs inactive
//   disp    sm_display_scan_if.slave
//             in : value[11:0], dp[2:0], lzb_en
//             out: seg[6:0] {g..a}, seg_dp, dig_sel[2:0], frame_tick
//
// Parameters:
//   DIV             cycles per digit slot (4..65535)
//   BLANK           dark cycles at the start of each slot (1..DIV-1)
//   SEG_ACTIVE_LOW  1: seg / seg_dp are driven low when lit
//   DIG_ACTIVE_LOW  1: dig_sel bits are driven low when enabled
// ----------------------------------------------------------------------------
module sm_display_scan #(
    parameter logic [15:0] DIV            = 16'd33333,
    parameter logic [15:0] BLANK          = 16'd1000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic               clkIn,
    input  logic               rst_n,
    sm_display_scan_if.slave   disp
);

    // ------------------------------------------------------------------
    // Idle (unlit) levels of the outputs
    // ------------------------------------------------------------------
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = SEG_ACTIVE_LOW ? 1'b1  : 1'b0;
    localparam logic [2:0] DIG_OFF = DIG_ACTIVE_LOW ? 3'b111 : 3'b000;

    typedef enum logic [1:0] {
        SLOT_0       = 2'd0,
        SLOT_1       = 2'd1,
        SLOT_2       = 2'd2,
        SLOT_ILLEGAL = 2'd3
    } slot_t;

    // ------------------------------------------------------------------
    // Hex nibble to active-high segment pattern {g,f,e,d,c,b,a}
    // ------------------------------------------------------------------
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'h0:    code = 7'h3F;
            4'h1:    code = 7'h06;
            4'h2:    code = 7'h5B;
            4'h3:    code = 7'h4F;
            4'h4:    code = 7'h66;
            4'h5:    code = 7'h6D;
            4'h6:    code = 7'h7D;
            4'h7:    code = 7'h07;
            4'h8:    code = 7'h7F;
            4'h9:    code = 7'h6F;
            4'hA:    code = 7'h77;
            4'hB:    code = 7'h7C;
            4'hC:    code = 7'h39;
            4'hD:    code = 7'h5E;
            4'hE:    code = 7'h79;
            default: code = 7'h71;
        endcase
        return code;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [15:0] cnt_q,        cnt_d;
    slot_t       slot_q,       slot_d;
    logic [11:0] snap_value_q, snap_value_d;
    logic [2:0]  snap_dp_q,    snap_dp_d;
    logic        snap_lzb_q,   snap_lzb_d;

    logic [6:0]  seg_q,        seg_d;
    logic        seg_dp_q,     seg_dp_d;
    logic [2:0]  dig_sel_q,    dig_sel_d;
    logic        frame_tick_q, frame_tick_d;

    // ------------------------------------------------------------------
    // Per-digit decode of the captured value
    // ------------------------------------------------------------------
    logic [3:0] nib   [3];
    logic [6:0] glyph [3];
    logic [2:0] digit_blank;

    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_digit
        assign nib[gi]   = snap_value_q[4*gi +: 4];
        assign glyph[gi] = hex_to_seg(nib[gi]);
    end

    // Leading-zero blanking ripples from the most significant digit down.
    // Digit 0 always shows so a zero value still reads "0".
    assign digit_blank[2] = snap_lzb_q && (nib[2] == 4'h0);
    assign digit_blank[1] = digit_blank[2] && (nib[1] == 4'h0);
    assign digit_blank[0] = 1'b0;

    // ------------------------------------------------------------------
    // Slot timing and frame snapshot
    // ------------------------------------------------------------------
    logic frame_start;
    assign frame_start = (slot_q == SLOT_0) && (cnt_q == 16'd0);

    always_comb begin
        cnt_d        = cnt_q + 16'd1;
        slot_d       = slot_q;
        snap_value_d = snap_value_q;
        snap_dp_d    = snap_dp_q;
        snap_lzb_d   = snap_lzb_q;

        // >= instead of == so an out-of-range count still wraps
        if (cnt_q >= DIV - 16'd1) begin
            cnt_d = 16'd0;
            case (slot_q)
                SLOT_0:  slot_d = SLOT_1;
                SLOT_1:  slot_d = SLOT_2;
                default: slot_d = SLOT_0;
            endcase
        end

        // An illegal slot is recovered on the very next edge.
        if (slot_q == SLOT_ILLEGAL) begin
            slot_d = SLOT_0;
        end

        if (frame_start) begin
            snap_value_d = disp.value;
            snap_dp_d    = disp.dp;
            snap_lzb_d   = disp.lzb_en;
        end
    end

    // ------------------------------------------------------------------
    // Next output drive, computed from the current cnt/slot/snapshot.
    // Built active-high first, then flipped to the configured polarity.
    // ------------------------------------------------------------------
    logic [2:0] dig_hi;
    logic [6:0] seg_hi;
    logic       dp_hi;

    always_comb begin
        dig_hi = 3'b000;
        seg_hi = 7'h00;
        dp_hi  = 1'b0;

        if (cnt_q >= BLANK) begin
            case (slot_q)
                SLOT_0: begin
                    dig_hi = 3'b001;
                    seg_hi = digit_blank[0] ? 7'h00 : glyph[0];
                    dp_hi  = snap_dp_q[0];
                end
                SLOT_1: begin
                    dig_hi = 3'b010;
                    seg_hi = digit_blank[1] ? 7'h00 : glyph[1];
                    dp_hi  = snap_dp_q[1];
                end
                SLOT_2: begin
                    dig_hi = 3'b100;
                    seg_hi = digit_blank[2] ? 7'h00 : glyph[2];
                    dp_hi  = snap_dp_q[2];
                end
                default: begin
                    // illegal slot: stay dark until recovered
                    dig_hi = 3'b000;
                    seg_hi = 7'h00;
                    dp_hi  = 1'b0;
                end
            endcase
        end

        dig_sel_d    = dig_hi ^ {3{DIG_ACTIVE_LOW}};
        seg_d        = seg_hi ^ {7{SEG_ACTIVE_LOW}};
        seg_dp_d     = dp_hi ^ SEG_ACTIVE_LOW;
        frame_tick_d = frame_start;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clkIn or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= 16'd0;
            slot_q       <= SLOT_0;
            snap_value_q <= 12'h000;
            snap_dp_q    <= 3'b000;
            snap_lzb_q   <= 1'b0;
            seg_q        <= SEG_OFF;
            seg_dp_q     <= DP_OFF;
            dig_sel_q    <= DIG_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            slot_q       <= slot_d;
            snap_value_q <= snap_value_d;
            snap_dp_q    <= snap_dp_d;
            snap_lzb_q   <= snap_lzb_d;
            seg_q        <= seg_d;
            seg_dp_q     <= seg_dp_d;
            dig_sel_q    <= dig_sel_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign disp.seg        = seg_q;
    assign disp.seg_dp     = seg_dp_q;
    assign disp.dig_sel    = dig_sel_q;
    assign disp.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sm_display_scan.sv
// ----------------------------------------------------------------------------
// tb_sm_display_scan
//
// Two scanners with DIV=8, BLANK=2 share clock and reset: one with active-low
// segments/digits, one with active-high. Each table entry describes one full
// frame (24 cycles) of the active-low instance; the active-high instance shows
// a constant FFF throughout. Outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_sm_display_scan;

    localparam logic [15:0] DIV   = 16'd8;
    localparam logic [15:0] BLANK = 16'd2;
    localparam int          FRAME = 24;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sm_display_scan_if bus_lo ();
    sm_display_scan_if bus_hi ();

    sm_display_scan #(
        .DIV            (DIV),
        .BLANK          (BLANK),
        .SEG_ACTIVE_LOW (1'b1),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut_lo (
        .clkIn (clk),
        .rst_n (rst_n),
        .disp  (bus_lo)
    );

    sm_display_scan #(
        .DIV            (DIV),
        .BLANK          (BLANK),
        .SEG_ACTIVE_LOW (1'b0),
        .DIG_ACTIVE_LOW (1'b0)
    ) dut_hi (
        .clkIn (clk),
        .rst_n (rst_n),
        .disp  (bus_hi)
    );

    // One frame of stimulus plus the hand-computed output levels of each slot.
    typedef struct {
        logic [11:0] value;
        logic [2:0]  dp;
        logic        lzb;
        int          chg_at;   // frame cycle after which value changes, -1 none
        logic [11:0] chg_val;
        logic [6:0]  seg0;     // seg level while digit 0 lit
        logic [6:0]  seg1;
        logic [6:0]  seg2;
        logic [2:0]  sdp;      // seg_dp level per digit while lit
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic vec_t mk(input logic [11:0] value, input logic [2:0] dp,
                                input logic lzb, input int chg_at,
                                input logic [11:0] chg_val,
                                input logic [6:0] seg0, input logic [6:0] seg1,
                                input logic [6:0] seg2, input logic [2:0] sdp);
        vec_t v;
        v.value   = value;
        v.dp      = dp;
        v.lzb     = lzb;
        v.chg_at  = chg_at;
        v.chg_val = chg_val;
        v.seg0    = seg0;
        v.seg1    = seg1;
        v.seg2    = seg2;
        v.sdp     = sdp;
        return v;
    endfunction

    // Compared word: {frame_tick, dig_sel[2:0], seg[6:0], seg_dp}
    task automatic check(input string tag, input int idx, input int cyc,
                         input logic [11:0] got, input logic [11:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s vec=%0d cyc=%0d got {ft,dig,seg,dp}=%b_%b_%h_%b expected=%b_%b_%h_%b",
                     tag, idx, cyc, got[11], got[10:8], got[7:1], got[0],
                     exp[11], exp[10:8], exp[7:1], exp[0]);
        end
    endtask

    function automatic logic [11:0] sample_lo();
        return {bus_lo.frame_tick, bus_lo.dig_sel, bus_lo.seg, bus_lo.seg_dp};
    endfunction

    function automatic logic [11:0] sample_hi();
        return {bus_hi.frame_tick, bus_hi.dig_sel, bus_hi.seg, bus_hi.seg_dp};
    endfunction

    // Runs ncyc cycles of a frame; must be called just before a snapshot edge.
    task automatic run_frame(input vec_t v, input int idx, input int ncyc);
        int          c;
        int          s;
        logic        ft;
        logic [2:0]  dig_lo;
        logic [2:0]  dig_hi;
        logic [6:0]  seg_lo;
        logic [11:0] exp_lo;
        logic [11:0] exp_hi;
        bus_lo.value  = v.value;
        bus_lo.dp     = v.dp;
        bus_lo.lzb_en = v.lzb;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            @(negedge clk);
            c  = i % 8;
            s  = i / 8;
            ft = (i == 0);
            case (s)
                0:       begin dig_lo = 3'b110; dig_hi = 3'b001; seg_lo = v.seg0; end
                1:       begin dig_lo = 3'b101; dig_hi = 3'b010; seg_lo = v.seg1; end
                default: begin dig_lo = 3'b011; dig_hi = 3'b100; seg_lo = v.seg2; end
            endcase
            if (c < 2) begin
                exp_lo = {ft, 3'b111, 7'h7F, 1'b1};
                exp_hi = {ft, 3'b000, 7'h00, 1'b0};
            end else begin
                exp_lo = {ft, dig_lo, seg_lo, v.sdp[s]};
                exp_hi = {ft, dig_hi, 7'h71, 1'b0};
            end
            check("scan_lo", idx, i, sample_lo(), exp_lo);
            check("scan_hi", idx, i, sample_hi(), exp_hi);
            if (i == v.chg_at) bus_lo.value = v.chg_val;
        end
    endtask

    vec_t vecs [9];

    initial begin
        vecs[0] = mk(12'h1A5, 3'b000, 1'b0, -1, 12'h000, ~7'h6D, ~7'h77, ~7'h06, 3'b111);
        vecs[1] = mk(12'h123, 3'b000, 1'b0, 10, 12'h456, ~7'h4F, ~7'h5B, ~7'h06, 3'b111);
        vecs[2] = mk(12'h456, 3'b000, 1'b0, -1, 12'h000, ~7'h7D, ~7'h6D, ~7'h66, 3'b111);
        vecs[3] = mk(12'h007, 3'b000, 1'b1, -1, 12'h000, ~7'h07, 7'h7F,  7'h7F,  3'b111);
        vecs[4] = mk(12'h070, 3'b000, 1'b1, -1, 12'h000, ~7'h3F, ~7'h07, 7'h7F,  3'b111);
        vecs[5] = mk(12'h000, 3'b010, 1'b1, -1, 12'h000, ~7'h3F, 7'h7F,  7'h7F,  3'b101);
        vecs[6] = mk(12'h100, 3'b000, 1'b1, -1, 12'h000, ~7'h3F, ~7'h3F, ~7'h06, 3'b111);
        vecs[7] = mk(12'h000, 3'b000, 1'b0, -1, 12'h000, ~7'h3F, ~7'h3F, ~7'h3F, 3'b111);
        vecs[8] = mk(12'hF0E, 3'b101, 1'b0, -1, 12'h000, ~7'h79, ~7'h3F, ~7'h71, 3'b010);

        bus_lo.value  = 12'h000;
        bus_lo.dp     = 3'b000;
        bus_lo.lzb_en = 1'b0;
        bus_hi.value  = 12'hFFF;
        bus_hi.dp     = 3'b000;
        bus_hi.lzb_en = 1'b0;

        // Reset levels
        #12;
        check("reset_lo", -1, 0, sample_lo(), {1'b0, 3'b111, 7'h7F, 1'b1});
        check("reset_hi", -1, 0, sample_hi(), {1'b0, 3'b000, 7'h00, 1'b0});

        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back frames from the table
        for (int k = 0; k < 9; k++) begin
            run_frame(vecs[k], k, FRAME);
        end

        // Reset mid-slot: stop right after the edge that leaves slot 1, cnt 5
        run_frame(vecs[0], 100, 13);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_lo", 100, 13, sample_lo(), {1'b0, 3'b111, 7'h7F, 1'b1});
        check("async_rst_hi", 100, 13, sample_hi(), {1'b0, 3'b000, 7'h00, 1'b0});
        for (int h = 0; h < 3; h++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_hold_lo", 101, h, sample_lo(), {1'b0, 3'b111, 7'h7F, 1'b1});
            check("rst_hold_hi", 101, h, sample_hi(), {1'b0, 3'b000, 7'h00, 1'b0});
        end
        rst_n = 1'b1;

        // Scan restarts at slot 0 with a fresh snapshot and frame_tick
        run_frame(vecs[8], 102, FRAME);
        run_frame(vecs[0], 103, FRAME);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
